// File: rtl/jk_pkg.sv
// jk_pkg: mode encodings shared by the JK bank and its bench
package jk_pkg;
  typedef enum logic [1:0] {
    MODE_JK = 2'b00,
    MODE_UP = 2'b01,
    MODE_DN = 2'b10,
    MODE_LD = 2'b11
  } mode_e;
endpackage

// File: rtl/jk_cell.sv
// jk_cell: single JK flip-flop with enable and synchronous active-low reset
module jk_cell (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic j,
  input  logic k,
  input  logic rst_val,
  output logic q
);
  // hold on 00, clear on 01, set on 10, toggle on 11
  always_ff @(posedge clk)
    if (!reset) q <= rst_val;
    else if (en) q <= (j & ~q) | (~k & q);
endmodule

// File: rtl/jk_bank.sv
// jk_bank: bank of JK cells steered as JK register, up/down counter or loader
module jk_bank
  import jk_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             tc,
  output logic             chg
);
  mode_e m;
  logic [WIDTH-1:0] up, dn, jv, kv, nxt;
  assign m = mode_e'(mode);
  // ripple-carry/borrow enables and per-mode J/K steering
  always_comb begin
    up[0] = 1'b1;
    dn[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      up[i] = up[i-1] & q[i-1];
      dn[i] = dn[i-1] & ~q[i-1];
    end
    jv  = m == MODE_UP ? up : m == MODE_DN ? dn : j;
    kv  = m == MODE_UP ? up : m == MODE_DN ? dn : m == MODE_LD ? ~j : k;
    nxt = (jv & ~q) | (~kv & q);
  end
  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    jk_cell u_cell (
      .clk(clk), .reset(reset), .en(en), .j(jv[g]), .k(kv[g]),
      .rst_val(RST_VAL[g]), .q(q[g])
    );
  end
  assign qn = ~q;
  assign tc = (m == MODE_UP && &q) || (m == MODE_DN && ~|q);
  // flag an enabled edge where the bank actually moved
  always_ff @(posedge clk)
    if (!reset) chg <= 1'b0;
    else chg <= en && (nxt != q);
endmodule
